// File: rtl/vbuf_wr_arb.sv
// Round-robin write arbiter for the frame buffer's single byte-write port.
// Four producers compete; the granted one keeps the port for a whole packet
// (until it flags its last byte or the burst limit is hit), and every issued
// byte is followed by GAP_CYCLES quiet cycles so the UART drain keeps up.
module vbuf_wr_arb #(
    parameter logic [10:0] GAP_CYCLES = 11'd1050,
    parameter logic [7:0]  MAX_BURST  = 8'd80
) (
    input  logic        vram_clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ack,
    output logic [3:0]  gnt,
    output logic [7:0]  data_in,
    output logic        data_in_rdy,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  ptr_q;        // index of the most recently granted producer
    logic [1:0]  gidx_q;       // index of the producer currently granted
    logic [7:0]  burst_cnt_q;
    logic [10:0] gap_cnt_q;
    logic        last_seen_q;
    logic [3:0]  gnt_q;
    logic [3:0]  req_ack_q;
    logic [7:0]  data_in_q;
    logic        data_in_rdy_q;
    logic        busy_q;

    // Per-producer byte lanes unpacked from the flat request bus.
    logic [7:0] lane [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    logic [1:0] pick_idx;
    logic [1:0] cand;

    // Round-robin pick: first requester after ptr_q, wrapping, ptr_q itself last.
    always_comb begin
        pick_idx = ptr_q;
        cand     = ptr_q;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr_q + 2'(k);
            if (req[cand]) begin
                pick_idx = cand;
            end
        end
    end

    // Arbitration FSM; every output is a register written here.
    always_ff @(posedge vram_clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= 2'd3;
            gidx_q        <= 2'd0;
            burst_cnt_q   <= 8'd0;
            gap_cnt_q     <= 11'd0;
            last_seen_q   <= 1'b0;
            gnt_q         <= 4'd0;
            req_ack_q     <= 4'd0;
            data_in_q     <= 8'h00;
            data_in_rdy_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            // Strobes are single-cycle; data_in keeps its last value.
            data_in_rdy_q <= 1'b0;
            req_ack_q     <= 4'd0;
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        gidx_q      <= pick_idx;
                        gnt_q       <= 4'(1) << pick_idx;
                        burst_cnt_q <= 8'd0;
                        last_seen_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (req[gidx_q]) begin
                        data_in_q     <= lane[gidx_q];
                        data_in_rdy_q <= 1'b1;
                        req_ack_q     <= 4'(1) << gidx_q;
                        burst_cnt_q   <= burst_cnt_q + 8'd1;
                        last_seen_q   <= req_last[gidx_q];
                        gap_cnt_q     <= GAP_CYCLES - 11'd1;
                        state_q       <= ST_GAP;
                    end else begin
                        // Producer withdrew: give up the grant without a byte.
                        gnt_q   <= 4'd0;
                        ptr_q   <= gidx_q;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == 11'd0) begin
                        if (last_seen_q || (burst_cnt_q == MAX_BURST)) begin
                            gnt_q   <= 4'd0;
                            ptr_q   <= gidx_q;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_SEND;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 11'd1;
                    end
                end
                default: begin
                    gnt_q   <= 4'd0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ack     = req_ack_q;
    assign gnt         = gnt_q;
    assign data_in     = data_in_q;
    assign data_in_rdy = data_in_rdy_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vbuf_wr_arb.sv
// Bench for vbuf_wr_arb: a cycle-by-cycle vector table for a single packet,
// a small producer model for the arbitration-order scenarios, and
// hand-written sequences for withdraw, mid-packet reset and default spacing.
module tb_vbuf_wr_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;

    logic [3:0]  a_ack, a_gnt, b_ack, b_gnt;
    logic [7:0]  a_din, b_din;
    logic        a_rdy, a_busy, b_rdy, b_busy;

    always #5 clk = ~clk;

    vbuf_wr_arb #(.GAP_CYCLES(11'd4), .MAX_BURST(8'd3)) dut_a (
        .vram_clk(clk), .reset(rst), .req(req), .req_data(req_data),
        .req_last(req_last), .req_ack(a_ack), .gnt(a_gnt), .data_in(a_din),
        .data_in_rdy(a_rdy), .busy(a_busy)
    );

    vbuf_wr_arb dut_b (
        .vram_clk(clk), .reset(rst), .req(req), .req_data(req_data),
        .req_last(req_last), .req_ack(b_ack), .gnt(b_gnt), .data_in(b_din),
        .data_in_rdy(b_rdy), .busy(b_busy)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] req;
        logic [7:0] d;
        logic       last;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic       rdy;
        logic [7:0] dout;
        logic       busy;
    } vec_t;

    vec_t tbl [17];

    // Producer model: per-producer byte queue, popped on each observed ack.
    logic [7:0] pdata [4][16];
    logic       plast [4][16];
    int         pn [4];
    int         pp [4];
    int         ev_idx [32];
    int         ev_n;

    function automatic vec_t mk(logic [3:0] r, logic [7:0] d, logic l,
                                logic [3:0] g, logic [3:0] a, logic y,
                                logic [7:0] o, logic b);
        vec_t v;
        v.req = r; v.d = d; v.last = l;
        v.gnt = g; v.ack = a; v.rdy = y; v.dout = o; v.busy = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'd0; req_data = 32'd0; req_last = 4'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            pn[i] = 0;
            pp[i] = 0;
        end
        ev_n = 0;
    endtask

    task automatic drive_model();
        for (int i = 0; i < 4; i++) begin
            if (pp[i] < pn[i]) begin
                req[i]             = 1'b1;
                req_data[8*i +: 8] = pdata[i][pp[i]];
                req_last[i]        = plast[i][pp[i]];
            end else begin
                req[i]             = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    // Runs the model against dut_a until every queue is drained and the DUT is idle.
    task automatic run_model(input int max_cycles, input string name);
        int  cyc;
        int  idx;
        bit  done;
        cyc  = 0;
        done = 1'b0;
        ev_n = 0;
        while (!done && cyc < max_cycles) begin
            drive_model();
            @(negedge clk);
            cyc++;
            if (a_rdy) begin
                idx = -1;
                for (int i = 0; i < 4; i++)
                    if (a_ack == (4'(1) << i)) idx = i;
                chk({name, "_ack_eq_gnt"}, {28'd0, a_ack}, {28'd0, a_gnt});
                if (idx < 0) begin
                    chk({name, "_ack_onehot"}, {28'd0, a_ack}, 32'd1);
                end else begin
                    chk($sformatf("%s_data%0d", name, ev_n), {24'd0, a_din},
                        {24'd0, pdata[idx][pp[idx]]});
                    if (ev_n < 32) ev_idx[ev_n] = idx;
                    ev_n++;
                    pp[idx]++;
                end
            end else if (a_ack != 4'd0) begin
                chk({name, "_ack_without_strobe"}, {28'd0, a_ack}, 32'd0);
            end
            done = !a_busy;
            for (int i = 0; i < 4; i++)
                if (pp[i] < pn[i]) done = 1'b0;
        end
        if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
        drive_model();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (a_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (a_busy) chk({name, "_idle_timeout"}, {31'd0, a_busy}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int exp2 [8];
        int exp3 [9];
        int t_str [3];
        int ns;
        int cyc;
        bit stable;
        logic [7:0] held;

        exp2 = '{0, 1, 2, 3, 0, 1, 2, 3};
        exp3 = '{1, 1, 1, 2, 1, 1, 1, 2, 1};

        // Single packet 1B,5B,48 (last on 48) with GAP_CYCLES=4, one row per cycle.
        tbl[0]  = mk(4'h1, 8'h1B, 1'b0, 4'h1, 4'h0, 1'b0, 8'h00, 1'b1);
        tbl[1]  = mk(4'h1, 8'h1B, 1'b0, 4'h1, 4'h1, 1'b1, 8'h1B, 1'b1);
        tbl[2]  = mk(4'h1, 8'h5B, 1'b0, 4'h1, 4'h0, 1'b0, 8'h1B, 1'b1);
        tbl[3]  = mk(4'h1, 8'h5B, 1'b0, 4'h1, 4'h0, 1'b0, 8'h1B, 1'b1);
        tbl[4]  = mk(4'h1, 8'h5B, 1'b0, 4'h1, 4'h0, 1'b0, 8'h1B, 1'b1);
        tbl[5]  = mk(4'h1, 8'h5B, 1'b0, 4'h1, 4'h0, 1'b0, 8'h1B, 1'b1);
        tbl[6]  = mk(4'h1, 8'h5B, 1'b0, 4'h1, 4'h1, 1'b1, 8'h5B, 1'b1);
        tbl[7]  = mk(4'h1, 8'h48, 1'b1, 4'h1, 4'h0, 1'b0, 8'h5B, 1'b1);
        tbl[8]  = mk(4'h1, 8'h48, 1'b1, 4'h1, 4'h0, 1'b0, 8'h5B, 1'b1);
        tbl[9]  = mk(4'h1, 8'h48, 1'b1, 4'h1, 4'h0, 1'b0, 8'h5B, 1'b1);
        tbl[10] = mk(4'h1, 8'h48, 1'b1, 4'h1, 4'h0, 1'b0, 8'h5B, 1'b1);
        tbl[11] = mk(4'h1, 8'h48, 1'b1, 4'h1, 4'h1, 1'b1, 8'h48, 1'b1);
        tbl[12] = mk(4'h0, 8'h00, 1'b0, 4'h1, 4'h0, 1'b0, 8'h48, 1'b1);
        tbl[13] = mk(4'h0, 8'h00, 1'b0, 4'h1, 4'h0, 1'b0, 8'h48, 1'b1);
        tbl[14] = mk(4'h0, 8'h00, 1'b0, 4'h1, 4'h0, 1'b0, 8'h48, 1'b1);
        tbl[15] = mk(4'h0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 8'h48, 1'b0);
        tbl[16] = mk(4'h0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 8'h48, 1'b0);

        clear_model();
        rst = 1'b1;
        req = 4'd0; req_data = 32'd0; req_last = 4'd0;
        repeat (3) @(negedge clk);

        // Reset values on both instances.
        chk("reset_a", {14'd0, a_gnt, a_ack, a_rdy, a_din, a_busy}, 32'd0);
        chk("reset_b", {14'd0, b_gnt, b_ack, b_rdy, b_din, b_busy}, 32'd0);
        rst = 1'b0;

        // Table-driven single-producer packet.
        for (int k = 0; k < 17; k++) begin
            req      = tbl[k].req;
            req_data = {24'd0, tbl[k].d};
            req_last = {3'd0, tbl[k].last};
            @(negedge clk);
            chk($sformatf("vec%0d", k),
                {14'd0, a_gnt, a_ack, a_rdy, a_din, a_busy},
                {14'd0, tbl[k].gnt, tbl[k].ack, tbl[k].rdy, tbl[k].dout, tbl[k].busy});
        end

        // All four request from reset, two 1-byte packets each: 0,1,2,3,0,1,2,3.
        do_reset();
        clear_model();
        for (int i = 0; i < 4; i++) begin
            pn[i] = 2;
            for (int r = 0; r < 2; r++) begin
                pdata[i][r] = 8'h40 + 8'(16 * i) + 8'(r);
                plast[i][r] = 1'b1;
            end
        end
        run_model(200, "rr");
        chk("rr_count", ev_n, 8);
        for (int k = 0; k < 8; k++)
            if (k < ev_n) chk($sformatf("rr_order%0d", k), ev_idx[k], exp2[k]);

        // Burst limit 3: req1 never flags last, req2 has two 1-byte packets.
        do_reset();
        clear_model();
        pn[1] = 7;
        for (int r = 0; r < 7; r++) begin
            pdata[1][r] = 8'hA0 + 8'(r);
            plast[1][r] = 1'b0;
        end
        pn[2] = 2;
        pdata[2][0] = 8'hC5; plast[2][0] = 1'b1;
        pdata[2][1] = 8'hC6; plast[2][1] = 1'b1;
        run_model(300, "burst");
        chk("burst_count", ev_n, 9);
        for (int k = 0; k < 9; k++)
            if (k < ev_n) chk($sformatf("burst_order%0d", k), ev_idx[k], exp3[k]);
        clear_model();

        // req0 withdraws in SEND; pending req1 takes over.
        do_reset();
        req      = 4'b0011;
        req_data = {16'd0, 8'h22, 8'h11};
        req_last = 4'b0011;
        @(negedge clk);
        chk("wd_gnt0", {14'd0, a_gnt, a_ack, a_rdy, a_din, a_busy},
            {14'd0, 4'b0001, 4'b0000, 1'b0, 8'h00, 1'b1});
        req = 4'b0010;
        @(negedge clk);
        chk("wd_release", {14'd0, a_gnt, a_ack, a_rdy, a_din, a_busy}, 32'd0);
        @(negedge clk);
        chk("wd_gnt1", {14'd0, a_gnt, a_ack, a_rdy, a_busy}, {14'd0, 4'b0010, 4'b0000, 1'b0, 1'b1});
        @(negedge clk);
        chk("wd_send1", {14'd0, a_gnt, a_ack, a_rdy, a_din, a_busy},
            {14'd0, 4'b0010, 4'b0010, 1'b1, 8'h22, 1'b1});
        req = 4'd0; req_last = 4'd0;
        wait_idle("wd");

        // Reset asserted in GAP of a packet, then restart.
        do_reset();
        req      = 4'b0001;
        req_data = {24'd0, 8'hC1};
        req_last = 4'd0;
        @(negedge clk);
        chk("rs_gnt", {28'd0, a_gnt}, 32'h1);
        @(negedge clk);
        chk("rs_first", {14'd0, a_gnt, a_ack, a_rdy, a_din, a_busy},
            {14'd0, 4'b0001, 4'b0001, 1'b1, 8'hC1, 1'b1});
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rs_async", {14'd0, a_gnt, a_ack, a_rdy, a_din, a_busy}, 32'd0);
        @(negedge clk);
        chk("rs_held", {14'd0, a_gnt, a_ack, a_rdy, a_din, a_busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rs_regnt", {14'd0, a_gnt, a_ack, a_rdy, a_busy}, {14'd0, 4'b0001, 4'b0000, 1'b0, 1'b1});
        @(negedge clk);
        chk("rs_restrobe", {14'd0, a_gnt, a_ack, a_rdy, a_din, a_busy},
            {14'd0, 4'b0001, 4'b0001, 1'b1, 8'hC1, 1'b1});
        req = 4'd0; req_data = 32'd0;
        wait_idle("rs");

        // Default parameters on dut_b: continuous req3, strobes 1051 cycles apart.
        do_reset();
        clear_model();
        pn[3] = 4;
        for (int r = 0; r < 4; r++) begin
            pdata[3][r] = 8'hD0 + 8'(r);
            plast[3][r] = 1'b0;
        end
        ns = 0; cyc = 0; stable = 1'b1; held = 8'h00;
        while (ns < 3 && cyc < 4000) begin
            drive_model();
            @(negedge clk);
            cyc++;
            if (b_rdy) begin
                t_str[ns] = cyc;
                chk($sformatf("dflt_data%0d", ns), {24'd0, b_din}, {24'd0, pdata[3][pp[3]]});
                pp[3]++;
                held = b_din;
                ns++;
            end else if (ns > 0 && b_din !== held) begin
                stable = 1'b0;
            end
        end
        chk("dflt_strobes", ns, 3);
        if (ns == 3) begin
            chk("dflt_spacing1", t_str[1] - t_str[0], 1051);
            chk("dflt_spacing2", t_str[2] - t_str[1], 1051);
        end
        chk("dflt_stable", {31'd0, stable}, 32'd1);
        clear_model();
        drive_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
